// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared event, direction and state types for count_event_monitor
package count_mon_pkg;
  typedef enum logic [1:0] {WRAP_UP = 2'd0, WRAP_DN = 2'd1, JUMP = 2'd2, DIR_CHANGE = 2'd3} evt_code_t;
  typedef enum logic [1:0] {NONE = 2'd0, UP = 2'd1, DOWN = 2'd2} dir_t;
  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} mon_state_t;
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: synchronous FIFO; a push while full lands when a pop frees a slot in the same cycle
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = mem_q[rd_q];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/count_event_monitor.sv
// count_event_monitor: classifies counter steps, counts wraps and queues notable events
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int EVT_DEPTH = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              mon_en,
  input  logic              clear,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [1:0]        evt_code,
  output logic [WIDTH-1:0]  evt_value,
  output logic [WRAP_W-1:0] wrap_up_cnt,
  output logic [WRAP_W-1:0] wrap_dn_cnt,
  output logic              overflow
);
  mon_state_t state_q, state_d;
  dir_t dir_q, dir_d;
  logic [WIDTH-1:0] prev_q, prev_d, delta;
  logic [WRAP_W-1:0] up_q, up_d, dn_q, dn_d;
  logic ovf_q, ovf_d;
  logic act, is_up, is_dn, jump, wup, wdn, dchg, push, full, empty;
  evt_code_t code;
  logic [WIDTH+1:0] head;
  always_comb begin
    delta = count_in - prev_q;
    act = state_q == TRACK && mon_en;
    is_up = delta == WIDTH'(1);
    is_dn = delta == '1;
    jump = delta != '0 && !is_up && !is_dn;
    wup = is_up && prev_q == '1;
    wdn = is_dn && prev_q == '0;
    dchg = (is_up && dir_q == DOWN) || (is_dn && dir_q == UP);
    push = act && (jump || wup || wdn || dchg);
    code = jump ? JUMP : wup ? WRAP_UP : wdn ? WRAP_DN : DIR_CHANGE;
    state_d = mon_en ? TRACK : IDLE;
    prev_d = mon_en ? count_in : prev_q;
    dir_d = !mon_en ? dir_q : (!act || jump) ? NONE : is_up ? UP : is_dn ? DOWN : dir_q;
    up_d = (act && wup && up_q != '1) ? up_q + 1'b1 : up_q;
    dn_d = (act && wdn && dn_q != '1) ? dn_q + 1'b1 : dn_q;
    // a drop only happens when no pop frees the head slot this cycle
    ovf_d = ovf_q || (push && full && !(evt_ready && !empty));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      state_q <= IDLE;
      prev_q <= '0;
      dir_q <= NONE;
      up_q <= '0;
      dn_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      dir_q <= dir_d;
      up_q <= up_d;
      dn_q <= dn_d;
      ovf_q <= ovf_d;
    end
  end
  evt_fifo #(.DEPTH(EVT_DEPTH), .DW(WIDTH + 2)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .push(push),
    .pop(evt_ready),
    .din({code, count_in}),
    .dout(head),
    .empty(empty),
    .full(full)
  );
  assign evt_valid = !empty;
  assign evt_code = head[WIDTH+1:WIDTH];
  assign evt_value = head[WIDTH-1:0];
  assign wrap_up_cnt = up_q;
  assign wrap_dn_cnt = dn_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_count_event_monitor.sv
// tb_count_event_monitor: directed scenario tests with hand-computed expectations
module tb_count_event_monitor;
  logic clk = 1'b0;
  logic reset, mon_en, clear, evt_ready;
  logic [2:0] count_in;
  logic evt_valid, overflow;
  logic [1:0] evt_code;
  logic [2:0] evt_value;
  logic [7:0] wrap_up_cnt, wrap_dn_cnt;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  count_event_monitor dut (
    .clk(clk), .reset(reset), .count_in(count_in), .mon_en(mon_en), .clear(clear),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code), .evt_value(evt_value),
    .wrap_up_cnt(wrap_up_cnt), .wrap_dn_cnt(wrap_dn_cnt), .overflow(overflow)
  );

  task automatic tick(input logic [2:0] v);
    count_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(count_in);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mon_en = 1'b0; clear = 1'b0; evt_ready = 1'b0; count_in = 3'd0;
    #13;
    checks++;
    if ({evt_valid, evt_code, evt_value, wrap_up_cnt, wrap_dn_cnt, overflow} !== 23'd0) begin
      errs++; $display("FAIL reset_values got %b want 0", {evt_valid, evt_code, evt_value, wrap_up_cnt, wrap_dn_cnt, overflow});
    end
    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b1;
    repeat (5) tick(3'd0);
    checks++;
    if ({evt_valid, wrap_up_cnt, wrap_dn_cnt, overflow} !== 18'd0) begin
      errs++; $display("FAIL hold_zero got %b want 0", {evt_valid, wrap_up_cnt, wrap_dn_cnt, overflow});
    end
  endtask

  task automatic test_wrap_dn();
    do_clear(); evt_ready = 1'b0; mon_en = 1'b1;
    tick(3'd0); tick(3'd7);
    checks++;
    if ({evt_valid, evt_code, evt_value, wrap_dn_cnt} !== {1'b1, 2'd1, 3'd7, 8'd1}) begin
      errs++; $display("FAIL wrap_dn_evt got %b want %b", {evt_valid, evt_code, evt_value, wrap_dn_cnt}, {1'b1, 2'd1, 3'd7, 8'd1});
    end
    tick(3'd6);
    checks++;
    if ({evt_valid, evt_code, evt_value} !== {1'b1, 2'd1, 3'd7}) begin
      errs++; $display("FAIL head_stable got %b want %b", {evt_valid, evt_code, evt_value}, {1'b1, 2'd1, 3'd7});
    end
    mon_en = 1'b0; evt_ready = 1'b1;
    tick(3'd6);
    checks++;
    if (evt_valid !== 1'b0) begin errs++; $display("FAIL wrap_dn_no_dirchg got %b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_dir_change();
    do_clear(); mon_en = 1'b1;
    tick(3'd3); tick(3'd4); tick(3'd5);
    checks++;
    if (evt_valid !== 1'b0) begin errs++; $display("FAIL up_steps_quiet got %b want 0", evt_valid); end
    tick(3'd4);
    checks++;
    if ({evt_valid, evt_code, evt_value} !== {1'b1, 2'd3, 3'd4}) begin
      errs++; $display("FAIL dir_change got %b want %b", {evt_valid, evt_code, evt_value}, {1'b1, 2'd3, 3'd4});
    end
    mon_en = 1'b0; evt_ready = 1'b1;
    tick(3'd4);
    checks++;
    if (evt_valid !== 1'b0) begin errs++; $display("FAIL dir_change_single got %b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_wrap_up();
    do_clear(); mon_en = 1'b1;
    tick(3'd7); tick(3'd0);
    checks++;
    if ({evt_valid, evt_code, evt_value, wrap_up_cnt} !== {1'b1, 2'd0, 3'd0, 8'd1}) begin
      errs++; $display("FAIL wrap_up_evt got %b want %b", {evt_valid, evt_code, evt_value, wrap_up_cnt}, {1'b1, 2'd0, 3'd0, 8'd1});
    end
  endtask

  task automatic test_jump();
    do_clear(); mon_en = 1'b1;
    tick(3'd2); tick(3'd6);
    checks++;
    if ({evt_valid, evt_code, evt_value} !== {1'b1, 2'd2, 3'd6}) begin
      errs++; $display("FAIL jump_evt got %b want %b", {evt_valid, evt_code, evt_value}, {1'b1, 2'd2, 3'd6});
    end
    tick(3'd5);
    mon_en = 1'b0; evt_ready = 1'b1;
    tick(3'd5);
    checks++;
    if (evt_valid !== 1'b0) begin errs++; $display("FAIL jump_clears_dir got %b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear(); evt_ready = 1'b0; mon_en = 1'b1;
    tick(3'd3); tick(3'd4); tick(3'd3); tick(3'd4); tick(3'd3); tick(3'd4); tick(3'd3);
    checks++;
    if ({evt_valid, overflow} !== 2'b11) begin errs++; $display("FAIL overflow_set got %b want 11", {evt_valid, overflow}); end
    mon_en = 1'b0; evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({evt_valid, evt_code, evt_value} !== {1'b1, 2'd3, (i % 2 == 0) ? 3'd3 : 3'd4}) begin
        errs++; $display("FAIL drain_%0d got %b want %b", i, {evt_valid, evt_code, evt_value}, {1'b1, 2'd3, (i % 2 == 0) ? 3'd3 : 3'd4});
      end
      tick(3'd3);
    end
    checks++;
    if ({evt_valid, overflow} !== 2'b01) begin errs++; $display("FAIL drained_empty got %b want 01", {evt_valid, overflow}); end
    evt_ready = 1'b0;
    do_clear();
    checks++;
    if ({evt_valid, wrap_up_cnt, wrap_dn_cnt, overflow} !== 18'd0) begin
      errs++; $display("FAIL clear_all got %b want 0", {evt_valid, wrap_up_cnt, wrap_dn_cnt, overflow});
    end
  endtask

  task automatic test_back_to_back();
    do_clear(); evt_ready = 1'b0; mon_en = 1'b1;
    tick(3'd3); tick(3'd4); tick(3'd3); tick(3'd4); tick(3'd3); tick(3'd4);
    evt_ready = 1'b1;
    tick(3'd3);
    checks++;
    if ({evt_valid, overflow} !== 2'b10) begin errs++; $display("FAIL full_push_pop got %b want 10", {evt_valid, overflow}); end
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({evt_valid, evt_code, evt_value} !== {1'b1, 2'd3, (i % 2 == 0) ? 3'd4 : 3'd3}) begin
        errs++; $display("FAIL b2b_drain_%0d got %b want %b", i, {evt_valid, evt_code, evt_value}, {1'b1, 2'd3, (i % 2 == 0) ? 3'd4 : 3'd3});
      end
      tick(3'd3);
    end
    checks++;
    if (evt_valid !== 1'b0) begin errs++; $display("FAIL b2b_empty got %b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_clear(); evt_ready = 1'b1; mon_en = 1'b1;
    tick(3'd0);
    for (int n = 0; n < 260; n++) begin
      for (int v = 1; v < 8; v++) tick(3'(v));
      tick(3'd0);
    end
    checks++;
    if ({wrap_up_cnt, wrap_dn_cnt, overflow} !== {8'hff, 8'd0, 1'b0}) begin
      errs++; $display("FAIL wrap_saturate got %b want %b", {wrap_up_cnt, wrap_dn_cnt, overflow}, {8'hff, 8'd0, 1'b0});
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_clear(); evt_ready = 1'b0; mon_en = 1'b1;
    tick(3'd3); tick(3'd4); tick(3'd3); tick(3'd4);
    mon_en = 1'b0; evt_ready = 1'b1;
    tick(3'd4);
    checks++;
    if ({evt_valid, evt_code, evt_value} !== {1'b1, 2'd3, 3'd4}) begin
      errs++; $display("FAIL mid_drain got %b want %b", {evt_valid, evt_code, evt_value}, {1'b1, 2'd3, 3'd4});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({evt_valid, evt_code, evt_value, wrap_up_cnt, wrap_dn_cnt, overflow} !== 23'd0) begin
      errs++; $display("FAIL async_reset got %b want 0", {evt_valid, evt_code, evt_value, wrap_up_cnt, wrap_dn_cnt, overflow});
    end
    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b1;
    tick(3'd5);
    checks++;
    if (evt_valid !== 1'b0) begin errs++; $display("FAIL first_sample got %b want 0", evt_valid); end
    tick(3'd5);
    checks++;
    if (evt_valid !== 1'b0) begin errs++; $display("FAIL post_reset_hold got %b want 0", evt_valid); end
  endtask

  initial begin
    test_reset();
    test_wrap_dn();
    test_dir_change();
    test_wrap_up();
    test_jump();
    test_overflow();
    test_back_to_back();
    test_saturation();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
